// File: rtl/alu_wb_pkg.sv
// alu_wb_pkg: shared encodings and branch-condition helper for the ALU writeback stage
package alu_wb_pkg;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_Z      = 2'b01,
        COND_C      = 2'b10,
        COND_NZ     = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        REG_R0 = 2'd0,
        REG_R1 = 2'd1,
        REG_R2 = 2'd2,
        REG_R3 = 2'd3
    } reg_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;

    function automatic logic cond_eval(input cond_e cond, input logic z, input logic c);
        return cond == COND_Z ? z : cond == COND_C ? c : cond == COND_NZ ? !z : 1'b1;
    endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// alu_wb_fifo: DEPTH-entry FIFO of packed writeback entries with occupancy count
module alu_wb_fifo #(
    parameter int W     = 13,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= (push_i && !pop_i) ? count_q + CW'(1) :
                       (pop_i && !push_i) ? count_q - CW'(1) : count_q;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: in-order commit of ALU results and flags, branch resolution after drain (option: ZERO_RECOMPUTE_EN)
module alu_writeback
    import alu_wb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEST_W = 2,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_set_flags,
    input  logic              in_flag_zero,
    input  logic              in_flag_carry,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [DATA_W-1:0] wr_data,
    output logic [DEST_W-1:0] wr_dest,
    output logic              flag_z,
    output logic              flag_c,
    input  logic              br_req,
    input  logic [1:0]        br_cond,
    output logic              br_done,
    output logic              br_taken
);
    localparam int EW = DEST_W + DATA_W + 3;
    localparam int CW = $clog2(DEPTH+1);

    logic [EW-1:0] head;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, zero_in;
    logic          head_sf, head_z, head_c;
    logic [1:0]    state_q, state_d;
    cond_e         cond_q, cond_d;
    logic          flag_z_q, flag_c_q;

`ifdef ZERO_RECOMPUTE_EN
    logic unused_flag_zero;
    assign unused_flag_zero = in_flag_zero;
    assign zero_in = in_result == '0;
`else
    assign zero_in = in_flag_zero;
`endif

    assign in_ready = !full && state_q != ST_DRAIN;
    assign push     = in_valid && in_ready;
    assign wr_valid = !empty;
    assign pop      = wr_valid && wr_ready;

    alu_wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({in_dest, in_result, in_set_flags, zero_in, in_flag_carry}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign {wr_dest, wr_data, head_sf, head_z, head_c} = head;

    // Branch FSM: latch the condition, wait for the FIFO to empty, then resolve for one cycle.
    always_comb begin
        state_d = (state_q == ST_IDLE && br_req)     ? ST_DRAIN   :
                  (state_q == ST_DRAIN && count == '0) ? ST_RESOLVE :
                  (state_q == ST_RESOLVE)              ? ST_IDLE    : state_q;
        cond_d  = (state_q == ST_IDLE && br_req) ? cond_e'(br_cond) : cond_q;
    end

    // Flags change only when a flag-setting entry commits; FSM state advances every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cond_q   <= COND_ALWAYS;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
            if (pop && head_sf) begin
                flag_z_q <= head_z;
                flag_c_q <= head_c;
            end
        end
    end

    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;
    assign br_done  = state_q == ST_RESOLVE;
    assign br_taken = br_done && cond_eval(cond_q, flag_z_q, flag_c_q);

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: vector table plus directed sequences, scoreboard on the register-file write port
module tb_alu_writeback;

`ifdef ZERO_RECOMPUTE_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_set_flags, in_flag_zero, in_flag_carry;
    logic [7:0] in_result;
    logic [1:0] in_dest;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic [1:0] wr_dest;
    logic       flag_z, flag_c;
    logic       br_req, br_done, br_taken;
    logic [1:0] br_cond;

    int checks = 0;
    int errors = 0;
    int n_push = 0;
    int n_pop  = 0;
    logic [9:0] sb[$];

    typedef struct {
        logic [7:0] res;
        logic [1:0] dest;
        logic       sf, z, c;
        logic       ez, ec;
    } vec_t;
    vec_t vt[8];

    alu_writeback #(.DATA_W(8), .DEST_W(2), .DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_dest       (in_dest),
        .in_set_flags  (in_set_flags),
        .in_flag_zero  (in_flag_zero),
        .in_flag_carry (in_flag_carry),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .wr_dest       (wr_dest),
        .flag_z        (flag_z),
        .flag_c        (flag_c),
        .br_req        (br_req),
        .br_cond       (br_cond),
        .br_done       (br_done),
        .br_taken      (br_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] r, input logic [1:0] d, input logic sf, input logic z, input logic c);
        in_valid = v;
        in_result = r;
        in_dest = d;
        in_set_flags = sf;
        in_flag_zero = z;
        in_flag_carry = c;
    endtask

    // Scoreboard: record accepted results, compare them as the write port drains
    always @(posedge clk) begin
        logic [9:0] e;
        if (rst) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back({in_dest, in_result});
                n_push++;
            end
            if (wr_valid && wr_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: write data %0h with no expected entry", wr_data);
                end else begin
                    e = sb.pop_front();
                    chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
                    chk("wr_dest", {30'd0, wr_dest}, {30'd0, e[9:8]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, q0, k;
        logic [3:0] exp_tk;
        vt[0] = '{8'h05, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[1] = '{8'h3C, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[2] = '{8'h00, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[3] = '{8'h7F, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{8'hFF, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[5] = '{8'h00, 2'd2, 1'b1, 1'b0, 1'b1, ZR,   1'b1};
        vt[6] = '{8'h10, 2'd0, 1'b1, 1'b1, 1'b0, !ZR,  1'b0};
        vt[7] = '{8'h22, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        wr_ready = 1'b1;
        br_req = 1'b0;
        br_cond = 2'b00;
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst_flag_z", {31'd0, flag_z}, 32'd0);
        chk("rst_flag_c", {31'd0, flag_c}, 32'd0);
        chk("rst_br_done", {31'd0, br_done}, 32'd0);
        chk("rst_br_taken", {31'd0, br_taken}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vt[i].res, vt[i].dest, vt[i].sf, vt[i].z, vt[i].c);
            #1;
            chk("no_comb_wr_valid", {31'd0, wr_valid}, 32'd0);
            tick();
            in_valid = 1'b0;
            chk("wr_valid_lat", {31'd0, wr_valid}, 32'd1);
            tick();
            chk($sformatf("vec%0d_flag_z", i), {31'd0, flag_z}, {31'd0, vt[i].ez});
            chk($sformatf("vec%0d_flag_c", i), {31'd0, flag_c}, {31'd0, vt[i].ec});
        end

        p0 = n_push;
        q0 = n_pop;
        wr_ready = 1'b0;
        drive(1'b1, 8'h11, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h22, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h33, 2'd2, 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("full_in_ready_hold", {31'd0, in_ready}, 32'd0);
        chk("stall_wr_data", {24'd0, wr_data}, 32'h11);
        wr_ready = 1'b1;
        chk("full_deq_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("after_deq_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("drained_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("push_count", n_push - p0, 32'd3);
        chk("pop_count", n_pop - q0, 32'd3);

        wr_ready = 1'b0;
        drive(1'b1, 8'h00, 2'd3, 1'b1, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        br_req = 1'b1;
        br_cond = 2'b01;
        tick();
        br_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("br3_wait_done", {31'd0, br_done}, 32'd0);
            tick();
        end
        chk("br3_flag_z_pre", {31'd0, flag_z}, 32'd0);
        wr_ready = 1'b1;
        k = 0;
        while (!br_done && k < 6) begin
            tick();
            k++;
        end
        chk("br3_done", {31'd0, br_done}, 32'd1);
        chk("br3_taken", {31'd0, br_taken}, 32'd1);
        chk("br3_flag_z", {31'd0, flag_z}, 32'd1);
        tick();
        chk("br3_done_pulse", {31'd0, br_done}, 32'd0);

        exp_tk = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            br_req = 1'b1;
            br_cond = c[1:0];
            chk("br4_c0_done", {31'd0, br_done}, 32'd0);
            tick();
            chk("br4_c1_done", {31'd0, br_done}, 32'd0);
            chk("br4_c1_in_ready", {31'd0, in_ready}, 32'd0);
            br_req = (c == 2);
            tick();
            chk($sformatf("br4_cond%0d_done", c), {31'd0, br_done}, 32'd1);
            chk($sformatf("br4_cond%0d_taken", c), {31'd0, br_taken}, {31'd0, exp_tk[c]});
            br_req = 1'b0;
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("br4_no_second_done", {31'd0, br_done}, 32'd0);
            end
        end

        drive(1'b1, 8'h01, 2'd0, 1'b1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_flag_c", {31'd0, flag_c}, 32'd1);
        wr_ready = 1'b0;
        drive(1'b1, 8'h44, 2'd1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 8'h55, 2'd2, 1'b1, 1'b1, 1'b1);
        br_req = 1'b1;
        br_cond = 2'b00;
        tick();
        in_valid = 1'b0;
        br_req = 1'b0;
        chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
        chk("drain_wr_valid", {31'd0, wr_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("mid_rst_flag_z", {31'd0, flag_z}, 32'd0);
        chk("mid_rst_flag_c", {31'd0, flag_c}, 32'd0);
        chk("mid_rst_br_done", {31'd0, br_done}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        wr_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("post_rst_br_done", {31'd0, br_done}, 32'd0);
            chk("post_rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
